lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter: SETUP_CYC, 2, cycles RS/DATA are stable before LCD_E rises (range 1..65535).
REQ-002 Parameter: E_HIGH_CYC, 12, cycles LCD_E is held high per byte (range 1..65535).
REQ-003 Parameter: HOLD_CYC, 2, cycles RS/DATA are held after LCD_E falls (range 1..65535).
REQ-004 Parameter: LONG_WAIT_CYC, 2000, extra cycles after a clear or home command (range 1..65535).
REQ-005 Port: clk  in  1  clock; all logic is rising-edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-high.
REQ-007 Port: req[2:0]  in  3  per-client write request; client 0 is the alarm/timer alert popup, 1 is the mode-display FSM, 2 is the idle/test client.
REQ-008 Port: rs_in[2:0]  in  3  per-client RS bit for the offered byte.
REQ-009 Port: data_in0, data_in1, data_in2  in  8 each  per-client offered byte.
REQ-010 Port: last[2:0]  in  3  per-client flag marking the offered byte as the final byte of its burst.
REQ-011 Port: grant[2:0]  out  3  one-hot owner of the LCD bus; all zero when idle.
REQ-012 Port: ack[2:0]  out  3  one-cycle pulse to the owner when its byte write completes.
REQ-013 Port: busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 Port: LCD_RS, LCD_RW, LCD_E  out  1 each  registered HD44780 control lines.
REQ-015 Port: LCD_DATA  out  8  registered HD44780 data bus.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, EHIGH, HOLD, LWAIT and NEXT.
- A 16-bit down-counter sets the dwell time in each timed state.
REQ-017 In IDLE, when any req bit is high, the arbiter SHALL select one client on that clock edge and move to SETUP.
- Fixed priority: 0 beats 1, 1 beats 2.
- Also on that edge: grant goes high for the selected client, and its rs_in/data_in/last are latched into LCD_RS, LCD_DATA and an internal last register.
REQ-018 Dwell times: SETUP lasts SETUP_CYC cycles with LCD_E=0; EHIGH lasts E_HIGH_CYC cycles with LCD_E=1; HOLD lasts HOLD_CYC cycles with LCD_E=0.
REQ-019 After HOLD, the FSM SHALL enter LWAIT for LONG_WAIT_CYC cycles only if the latched byte has RS=0 and DATA is 8'h01, 8'h02 or 8'h03; otherwise it goes straight to NEXT.
REQ-020 ack for the owner SHALL pulse high for exactly one cycle, in the final cycle of HOLD, or of LWAIT when LWAIT is taken.
REQ-021 NEXT SHALL last exactly one cycle:
- if the latched last was 0 and the owner's req is high, latch the owner's new rs_in/data_in/last and go to SETUP, keeping grant;
- otherwise clear grant and go to IDLE.
REQ-022 Grant SHALL NOT change while not in IDLE, even if a higher-priority req rises mid-burst.
REQ-023 If the owner drops req during SETUP, EHIGH, HOLD or LWAIT, the in-flight byte SHALL still complete with ack, and the burst ends at NEXT.
REQ-024 LCD_RW SHALL be constant 0; LCD_RS and LCD_DATA SHALL change only on entry to SETUP.
REQ-025 Per-byte latency SHALL be SETUP_CYC+E_HIGH_CYC+HOLD_CYC(+LONG_WAIT_CYC)+1 cycles, with one idle gap cycle (NEXT) between bytes of a burst.
REQ-026 busy SHALL be low only in IDLE; ack and grant SHALL never have more than one bit set.

Reset
REQ-027 While rst is high:
- state=IDLE and counter=0;
- grant=0, ack=0, busy=0;
- LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00.
REQ-028 A reset asserted mid-byte SHALL drop LCD_E immediately, without waiting for a clock, and discard the burst; no ack is issued.

Configuration
REQ-029 Macro LCD_ARB_ROUND_ROBIN_EN selects the arbitration policy applied in IDLE:
- when defined: round-robin, searching from (previous owner + 1) mod 3, with the pointer reset to client 2 so that client 0 wins first;
- when undefined: fixed priority per REQ-017.
- Bursts are never preempted in either case.

Verification
REQ-030 Defaults; req=3'b010, rs=1, data="A", last=1 -> LCD_E high for 12 cycles starting 2 cycles after grant[1]; ack[1] pulses at cycle 16; grant clears at cycle 17.
REQ-031 req[1] burst of 16 bytes ("MODE : 24H TYPE "), with req[0] raised at byte 5 -> all 16 bytes on LCD_DATA in order; grant[0] asserts only after grant[1] clears.
REQ-032 Client 1 sends rs=0, data=8'h01 -> LWAIT entered; ack[1] arrives 2016 cycles after grant; rs=0, data=8'h38 -> ack after 16 cycles.
REQ-033 req=3'b111 held with single-byte bursts -> without macro, grant order 0,0,0...; with LCD_ARB_ROUND_ROBIN_EN, order 0,1,2,0.
REQ-034 rst pulsed while EHIGH and LCD_E=1 -> LCD_E, grant and busy are 0 before the next clk edge; no ack; a new req is served normally after release.
REQ-035 Owner drops req during EHIGH with last=0 -> byte completes with ack, then IDLE at NEXT, grant=0.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780 write port between three byte-stream
// clients. A burst of bytes from the granted client is written with
// programmable setup / E-high / hold timing. Clear and home commands
// (RS=0, DATA 01..03) add a long post-write wait.
// Optional build macro: LCD_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration in IDLE. When it is undefined, client 0 has the highest
// priority and client 2 the lowest.
module lcd_bus_arbiter #(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int HOLD_CYC      = 2,
  parameter int LONG_WAIT_CYC = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] rs_in,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [2:0] last,
  output logic [2:0] grant,
  output logic [2:0] ack,
  output logic       busy,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DATA
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EHIGH = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_LWAIT = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  // The counter is loaded with (dwell - 1); a state ends in the cycle where
  // the counter reads zero.
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] EHIGH_LD = 16'(E_HIGH_CYC - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] LWAIT_LD = 16'(LONG_WAIT_CYC - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [1:0]  owner;
  logic        last_q;
  logic [1:0]  sel;
  logic [1:0]  src;
  logic        src_req;
  logic        src_rs;
  logic        src_last;
  logic [7:0]  src_data;
  logic        long_cmd;
  logic        byte_done;

`ifdef LCD_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;

  // Round-robin pick: search starts at the client after the previous owner.
  always_comb begin
    case (ptr)
      2'd0:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Remember the last winner; reset value 2 lets client 0 win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 2'd2;
    else if (state == S_IDLE && req != 3'b000)
      ptr <= sel;
  end
`else
  // Fixed-priority pick: the lowest-numbered requesting client wins.
  always_comb begin
    sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  end
`endif

  // Route the selected client (IDLE) or the current owner (NEXT) to the latch.
  always_comb begin
    src = (state == S_IDLE) ? sel : owner;
    case (src)
      2'd0: begin
        src_req  = req[0];
        src_rs   = rs_in[0];
        src_last = last[0];
        src_data = data_in0;
      end
      2'd1: begin
        src_req  = req[1];
        src_rs   = rs_in[1];
        src_last = last[1];
        src_data = data_in1;
      end
      default: begin
        src_req  = req[2];
        src_rs   = rs_in[2];
        src_last = last[2];
        src_data = data_in2;
      end
    endcase
  end

  // A clear or home command requires the long wait after its write.
  assign long_cmd  = !LCD_RS && (LCD_DATA == 8'h01 || LCD_DATA == 8'h02 ||
                                 LCD_DATA == 8'h03);
  assign byte_done = (cnt == 16'd0) &&
                     ((state == S_HOLD && !long_cmd) || state == S_LWAIT);
  assign ack       = byte_done ? grant : 3'b000;
  assign busy      = (state != S_IDLE);
  assign LCD_RW    = 1'b0;

  // Main sequencer: arbitrate, then step through the byte timing.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 16'd0;
      owner    <= 2'd0;
      last_q   <= 1'b0;
      grant    <= 3'b000;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 3'b000) begin
            owner    <= sel;
            grant    <= 3'b001 << sel;
            LCD_RS   <= src_rs;
            LCD_DATA <= src_data;
            last_q   <= src_last;
            cnt      <= SETUP_LD;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == 16'd0) begin
            LCD_E <= 1'b1;
            cnt   <= EHIGH_LD;
            state <= S_EHIGH;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_EHIGH: begin
          if (cnt == 16'd0) begin
            LCD_E <= 1'b0;
            cnt   <= HOLD_LD;
            state <= S_HOLD;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_HOLD: begin
          if (cnt == 16'd0) begin
            if (long_cmd) begin
              cnt   <= LWAIT_LD;
              state <= S_LWAIT;
            end else begin
              state <= S_NEXT;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_LWAIT: begin
          if (cnt == 16'd0)
            state <= S_NEXT;
          else
            cnt <= cnt - 16'd1;
        end
        S_NEXT: begin
          if (!last_q && src_req) begin
            LCD_RS   <= src_rs;
            LCD_DATA <= src_data;
            last_q   <= src_last;
            cnt      <= SETUP_LD;
            state    <= S_SETUP;
          end else begin
            grant <= 3'b000;
            state <= S_IDLE;
          end
        end
        default: begin
          grant <= 3'b000;
          LCD_E <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Testbench for lcd_bus_arbiter. The clients are driven from per-client byte
// queues. A transaction-level model orders the expected bytes, and a monitor
// checks each written byte, its timing and its ack against that order.
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       last;
  } byte_t;

  typedef struct {
    int         client;
    logic       rs;
    logic [7:0] data;
    bit         lwait;
  } exp_t;

  localparam int E_HIGH = 12;
  localparam int LONG_W = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, rs_in, last;
  logic [7:0] data_in0, data_in1, data_in2;
  logic [2:0] grant, ack;
  logic       busy, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] LCD_DATA;

  lcd_bus_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .rs_in(rs_in),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2),
    .last(last), .grant(grant), .ack(ack), .busy(busy),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DATA(LCD_DATA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  byte_t cq[3][$];
  exp_t  exp_q[$];
  int    rr_last = 2;

  // Monitor state.
  exp_t cur;
  bit   have_cur = 0;
  bit   gap_open = 0;
  bit   e_prev = 0;
  bit   g_prev = 0;
  int   e_rise_c = 0;
  int   last_ack_c = 0;
  int   grant_rise_c = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic present(input int k);
    byte_t b;
    b = cq[k][0];
    rs_in[k] = b.rs;
    last[k]  = b.last;
    case (k)
      0:       data_in0 = b.data;
      1:       data_in1 = b.data;
      default: data_in2 = b.data;
    endcase
  endtask

  task automatic start_client(input int k);
    present(k);
    req[k] = 1'b1;
  endtask

  task automatic push_exp(input int k, input byte_t b);
    exp_t e;
    e.client = k;
    e.rs     = b.rs;
    e.data   = b.data;
    e.lwait  = (b.rs == 1'b0) && (b.data >= 8'h01) && (b.data <= 8'h03);
    exp_q.push_back(e);
  endtask

  // Transaction-level model: whole bursts are granted one at a time and are
  // never interrupted. The winner is chosen from the clients with work left.
  task automatic model_round();
    byte_t mq[3][$];
    byte_t b;
    int    owner;
    for (int k = 0; k < 3; k++) mq[k] = cq[k];
    forever begin
      owner = -1;
`ifdef LCD_ARB_ROUND_ROBIN_EN
      for (int i = 1; i <= 3; i++)
        if (owner < 0 && mq[(rr_last + i) % 3].size() > 0) owner = (rr_last + i) % 3;
`else
      for (int k = 0; k < 3; k++)
        if (owner < 0 && mq[k].size() > 0) owner = k;
`endif
      if (owner < 0) break;
      do begin
        b = mq[owner].pop_front();
        push_exp(owner, b);
      end while (!b.last && mq[owner].size() > 0);
      rr_last = owner;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !have_cur && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {31'd0, exp_q.size() == 0 && !have_cur && !busy}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_e(input int budget);
    int n = 0;
    while (!LCD_E && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("e_seen", {31'd0, LCD_E}, 32'd1);
  endtask

  task automatic run_round();
    int n = 0;
    int nl = 0;
    for (int k = 0; k < 3; k++) begin
      n += cq[k].size();
      foreach (cq[k][i])
        if (!cq[k][i].rs && cq[k][i].data >= 8'h01 && cq[k][i].data <= 8'h03) nl++;
    end
    model_round();
    for (int k = 0; k < 3; k++)
      if (cq[k].size() > 0) start_client(k);
    wait_idle(200 + n * 40 + nl * LONG_W);
  endtask

  // Client behaviour: advance to the next queued byte on each ack and drop
  // the request once nothing is left.
  task automatic driver_loop();
    forever begin
      @(negedge clk);
      if (!rst)
        for (int k = 0; k < 3; k++)
          if (ack[k]) begin
            if (cq[k].size() > 0) void'(cq[k].pop_front());
            if (cq[k].size() > 0) present(k);
            else req[k] = 1'b0;
          end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        have_cur = 0;
        gap_open = 0;
        e_prev   = 0;
        g_prev   = 0;
      end else begin
        check("grant_onehot", {31'd0, $onehot0(grant)}, 32'd1);
        check("ack_onehot", {31'd0, $onehot0(ack)}, 32'd1);
        check("busy_vs_grant", {31'd0, busy}, {31'd0, grant != 3'b000});
        check("rw_low", {31'd0, LCD_RW}, 32'd0);
        if (grant != 3'b000 && !g_prev) grant_rise_c = cyc;
        if (LCD_E && !e_prev) begin
          check("byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            have_cur = 1;
            e_rise_c = cyc;
            check("grant_owner", {29'd0, grant}, 32'(1 << cur.client));
            check("byte_value", {23'd0, LCD_RS, LCD_DATA}, {23'd0, cur.rs, cur.data});
            if (gap_open) check("burst_gap", cyc - last_ack_c, 32'd4);
            else check("setup_time", cyc - grant_rise_c, 32'd2);
            gap_open = 0;
          end
        end
        if (!LCD_E && e_prev) check("e_high_len", cyc - e_rise_c, E_HIGH);
        if (ack != 3'b000) begin
          check("ack_expected", {31'd0, have_cur}, 32'd1);
          if (have_cur) begin
            check("ack_owner", {29'd0, ack}, 32'(1 << cur.client));
            check("ack_time", cyc - e_rise_c, 13 + (cur.lwait ? LONG_W : 0));
            check("byte_stable", {23'd0, LCD_RS, LCD_DATA}, {23'd0, cur.rs, cur.data});
          end
          have_cur   = 0;
          last_ack_c = cyc;
          gap_open   = 1;
        end
        if (grant == 3'b000 && g_prev) begin
          check("grant_release", cyc - last_ack_c, 32'd2);
          gap_open = 0;
        end
        e_prev = LCD_E;
        g_prev = (grant != 3'b000);
      end
    end
  endtask

  initial begin
    string s;
    byte_t b;
    rst = 1'b1;
    req = '0; rs_in = '0; last = '0;
    data_in0 = '0; data_in1 = '0; data_in2 = '0;
    fork
      driver_loop();
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    check("rst_grant", {29'd0, grant}, 32'd0);
    check("rst_ack", {29'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lcd", {21'd0, LCD_E, LCD_RS, LCD_RW, LCD_DATA}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single data byte "A" from client 1.
    cq[1].push_back('{1'b1, 8'h41, 1'b1});
    run_round();

    // Clear display (long wait), then a function-set byte (no long wait).
    cq[1].push_back('{1'b0, 8'h01, 1'b1});
    cq[1].push_back('{1'b0, 8'h38, 1'b1});
    run_round();

    // All clients request continuously with single-byte bursts.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) cq[k].push_back('{1'b1, 8'(8'h30 + k * 3 + i), 1'b1});
    run_round();

    // 16-byte burst from client 1; client 0 requests mid-burst and must wait.
    s = "MODE : 24H TYPE ";
    for (int i = 0; i < 16; i++) begin
      b = '{1'b1, s[i], (i == 15)};
      cq[1].push_back(b);
      push_exp(1, b);
    end
    start_client(1);
    for (int n = 0; n < 400 && cq[1].size() > 11; n++) @(negedge clk);
    b = '{1'b1, 8'h21, 1'b1};
    cq[0].push_back(b);
    push_exp(0, b);
    start_client(0);
    rr_last = 0;
    wait_idle(1000);

    // Owner withdraws during E-high with last=0: the byte completes, burst ends.
    b = '{1'b1, 8'h55, 1'b0};
    cq[1].push_back(b);
    push_exp(1, b);
    rr_last = 1;
    start_client(1);
    wait_e(40);
    req[1] = 1'b0;
    wait_idle(100);
    check("drop_grant", {29'd0, grant}, 32'd0);

    // Reset mid-byte while E is high.
    b = '{1'b1, 8'h42, 1'b1};
    cq[2].push_back(b);
    push_exp(2, b);
    start_client(2);
    wait_e(40);
    #1 rst = 1'b1;
    #1;
    check("arst_e", {31'd0, LCD_E}, 32'd0);
    check("arst_grant", {29'd0, grant}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ack", {29'd0, ack}, 32'd0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) cq[k].delete();
    req = '0;
    rr_last = 2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cq[2].push_back('{1'b1, 8'h43, 1'b1});
    run_round();

    // Randomized rounds.
    for (int r = 0; r < 12; r++) begin
      bit any = 0;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(1, 0) == 1 || (k == 2 && !any)) begin
          int nb = $urandom_range(2, 1);
          any = 1;
          for (int j = 0; j < nb; j++) begin
            int len = $urandom_range(3, 1);
            for (int i = 0; i < len; i++) begin
              if ($urandom_range(19, 0) == 0) b = '{1'b0, 8'($urandom_range(3, 1)), 1'b0};
              else b = '{1'($urandom), 8'($urandom), 1'b0};
              b.last = (i == len - 1);
              cq[k].push_back(b);
            end
          end
        end
      end
      run_round();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
